// File: rtl/spram_arbiter_if.sv
// Requester-side bus of the single-port RAM arbiter.
// One instance carries one master's request, grant and read-return signals.
interface spram_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 8
) ();

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    // Requester view: drives the request, receives grant and read data
    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    // Arbiter view: receives the request, drives grant and read data
    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/spram_arbiter.sv
// Two-requester arbiter and sequencer for a single-port RAM with a
// registered read address. Every access takes one ACCESS cycle; reads add
// a settle cycle and a capture cycle before the data is returned.
module spram_arbiter #(
    parameter int AW         = 6,
    parameter int DW         = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    spram_arbiter_if.slave    port0,
    spram_arbiter_if.slave    port1,
    output logic [DW-1:0]     ram_data,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_we,
    input  logic [DW-1:0]     ram_q,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RD_WAIT,
        RD_CAP
    } state_t;

    state_t        state;
    state_t        state_next;

    // last_grant remembers which requester was served most recently so
    // that a tie goes to the other one under round-robin
    logic          last_grant;
    logic          last_grant_next;
    logic          winner;
    logic          winner_next;
    logic          op_read;
    logic          op_read_next;

    logic [AW-1:0] ram_addr_next;
    logic [DW-1:0] ram_data_next;
    logic          ram_we_next;

    logic          gnt0;
    logic          gnt0_next;
    logic          gnt1;
    logic          gnt1_next;
    logic          rvalid0;
    logic          rvalid0_next;
    logic          rvalid1;
    logic          rvalid1_next;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata0_next;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata1_next;

    logic          any_req;
    logic          pick1;

    // Decide who would win if a grant were issued this cycle
    always_comb begin
        any_req = port0.req | port1.req;
        if (FIXED_PRIO != 0) begin
            pick1 = port1.req & ~port0.req;
        end else begin
            pick1 = port1.req & (~port0.req | ~last_grant);
        end
    end

    // Next-state and registered-output values for the sequencer
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        winner_next     = winner;
        op_read_next    = op_read;
        ram_addr_next   = ram_addr;
        ram_data_next   = ram_data;
        ram_we_next     = 1'b0;
        gnt0_next       = 1'b0;
        gnt1_next       = 1'b0;
        rvalid0_next    = 1'b0;
        rvalid1_next    = 1'b0;
        rdata0_next     = rdata0;
        rdata1_next     = rdata1;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next      = ACCESS;
                    winner_next     = pick1;
                    last_grant_next = pick1;
                    if (pick1) begin
                        ram_addr_next = port1.addr;
                        ram_data_next = port1.wdata;
                        ram_we_next   = port1.we;
                        op_read_next  = ~port1.we;
                        gnt1_next     = 1'b1;
                    end else begin
                        ram_addr_next = port0.addr;
                        ram_data_next = port0.wdata;
                        ram_we_next   = port0.we;
                        op_read_next  = ~port0.we;
                        gnt0_next     = 1'b1;
                    end
                end
            end

            ACCESS: begin
                if (op_read) begin
                    state_next = RD_WAIT;
                end else begin
                    state_next = IDLE;
                end
            end

            RD_WAIT: begin
                state_next = RD_CAP;
            end

            RD_CAP: begin
                state_next = IDLE;
                if (winner) begin
                    rdata1_next  = ram_q;
                    rvalid1_next = 1'b1;
                end else begin
                    rdata0_next  = ram_q;
                    rvalid0_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            winner     <= 1'b0;
            op_read    <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_we     <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            winner     <= winner_next;
            op_read    <= op_read_next;
            ram_addr   <= ram_addr_next;
            ram_data   <= ram_data_next;
            ram_we     <= ram_we_next;
            gnt0       <= gnt0_next;
            gnt1       <= gnt1_next;
            rvalid0    <= rvalid0_next;
            rvalid1    <= rvalid1_next;
            rdata0     <= rdata0_next;
            rdata1     <= rdata1_next;
        end
    end

    // Drive the requester buses and status from the registers
    always_comb begin
        port0.gnt    = gnt0;
        port0.rvalid = rvalid0;
        port0.rdata  = rdata0;
        port1.gnt    = gnt1;
        port1.rvalid = rvalid1;
        port1.rdata  = rdata1;
        busy         = (state != IDLE);
    end

endmodule
